// File: rtl/busy_arbiter_if.sv
// Request/grant bundle between client FSMs and the shared busy-timer arbiter.
// Client side drives requests and run lengths; the arbiter side drives grant/status.
interface busy_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned IW   = 2
);
    logic [NREQ-1:0]    i_req;
    logic [NREQ*CW-1:0] i_len;
    logic [NREQ-1:0]    o_grant;
    logic [IW-1:0]      o_owner;
    logic               o_busy;
    logic               o_done;
    logic               o_aborted;

    modport master (
        output i_req, i_len,
        input  o_grant, o_owner, o_busy, o_done, o_aborted
    );

    modport slave (
        input  i_req, i_len,
        output o_grant, o_owner, o_busy, o_done, o_aborted
    );
endinterface

// File: rtl/busy_arbiter.sv
// Round-robin arbiter sharing one countdown busy timer among NREQ requesters.
// The owner keeps its grant for max(len,1) cycles, then sees a one-cycle done pulse.
module busy_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned IW   = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    busy_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [NREQ-1:0]   grant, grant_n;
    logic [IW-1:0]     owner, owner_n;
    logic [IW-1:0]     rr, rr_n;
    logic              done, done_n;
    logic              aborted, aborted_n;

    logic              found;
    logic [IW-1:0]     sel;
    logic [CW-1:0]     len_sel;
    int unsigned       pos;
    logic [NREQ-1:0]   req_sh;
    logic [NREQ*CW-1:0] len_sh;
    logic [NREQ-1:0]   owner_req_sh;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            grant   <= '0;
            owner   <= '0;
            rr      <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            grant   <= grant_n;
            owner   <= owner_n;
            rr      <= rr_n;
            done    <= done_n;
            aborted <= aborted_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        grant_n      = grant;
        owner_n      = owner;
        rr_n         = rr;
        done_n       = 1'b0;
        aborted_n    = aborted;
        found        = 1'b0;
        sel          = '0;
        len_sel      = '0;
        pos          = 0;
        req_sh       = '0;
        len_sh       = '0;
        owner_req_sh = bus.i_req >> owner;

        // Walk upward from the rr pointer with wrap; shifts avoid variable-width bit selects.
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos    = (32'(rr) + i) % NREQ;
            req_sh = bus.i_req >> pos;
            if (!found && req_sh[0]) begin
                found   = 1'b1;
                sel     = IW'(pos);
                len_sh  = bus.i_len >> (pos * CW);
                len_sel = len_sh[CW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n        = RUN;
                    grant_n        = '0;
                    grant_n[sel]   = 1'b1;
                    owner_n        = sel;
                    cnt_n          = (len_sel == '0) ? CW'(1) : len_sel;
                    aborted_n      = 1'b0;
                end
            end
            RUN: begin
                if (!owner_req_sh[0]) begin
                    state_n   = DONE;
                    cnt_n     = '0;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (cnt == CW'(1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                state_n   = IDLE;
                grant_n   = '0;
                aborted_n = 1'b0;
                rr_n      = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.o_grant   = grant;
    assign bus.o_owner   = owner;
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_done    = done;
    assign bus.o_aborted = aborted;
endmodule
